// File: rtl/elevator_car_sim_pkg.sv
// Shared definitions for the elevator car model and its controller:
// the motor command encoding and the floor index type.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 3;
  localparam int unsigned FLOOR_W    = 2;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    CMD_STOP = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10,
    CMD_BAD  = 2'b11
  } move_cmd_e;

endpackage

// File: rtl/elevator_car_sim_if.sv
// Motor-command / floor-switch link between the elevator controller (master)
// and the car/shaft model (slave).
interface elevator_car_sim_if;

  logic [1:0]            move_cmd;
  logic                  switch1;
  logic                  switch2;
  logic                  switch3;
  elevator_pkg::floor_t  car_floor;
  logic                  moving;
  logic                  arrive;
  logic                  fault;

  modport master (
    output move_cmd,
    input  switch1, switch2, switch3, car_floor, moving, arrive, fault
  );

  modport slave (
    input  move_cmd,
    output switch1, switch2, switch3, car_floor, moving, arrive, fault
  );

endinterface

// File: rtl/elevator_car_sim_tick_gen.sv
// Free-running prescaler: step_c is high for one cycle out of every PRESCALE.
module tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  output logic step_c
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign step_c = (cnt == LAST);

endmodule

// File: rtl/elevator_car_sim.sv
// Elevator car and shaft model: integrates up/down commands into a floor/sub-step
// position, drives the floor alignment switches and latches overtravel faults.
module elevator_car_sim
  import elevator_pkg::*;
#(
  parameter int unsigned TICKS_PER_FLOOR = 8,
  parameter int unsigned PRESCALE        = 4
) (
  input  logic               clk,
  input  logic               reset,
  elevator_car_sim_if.slave  bus
);

  localparam int unsigned SUB_W = $clog2(TICKS_PER_FLOOR);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_PER_FLOOR - 1);
  localparam logic [SUB_W-1:0] SUB_ONE   = SUB_W'(1);
  localparam floor_t           TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  logic step_c;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .step_c (step_c)
  );

  move_cmd_e cmd;
  assign cmd = move_cmd_e'(bus.move_cmd);

  floor_t                 floor_q,  floor_d;
  logic [SUB_W-1:0]       sub_q,    sub_d;
  logic                   fault_q,  fault_d;
  logic                   moving_q, moving_d;
  logic                   arrive_q, arrive_d;
  logic [NUM_FLOORS-1:0]  sw_q,     sw_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      floor_q  <= '0;
      sub_q    <= '0;
      fault_q  <= 1'b0;
      moving_q <= 1'b0;
      arrive_q <= 1'b0;
      sw_q     <= NUM_FLOORS'(1);
    end else begin
      floor_q  <= floor_d;
      sub_q    <= sub_d;
      fault_q  <= fault_d;
      moving_q <= moving_d;
      arrive_q <= arrive_d;
      sw_q     <= sw_d;
    end
  end

  // Position update on each step strobe; a latched fault freezes the car.
  always_comb begin
    floor_d  = floor_q;
    sub_d    = sub_q;
    fault_d  = fault_q;
    moving_d = moving_q;
    arrive_d = 1'b0;
    if (step_c) begin
      moving_d = 1'b0;
      if (!fault_q) begin
        case (cmd)
          CMD_UP: begin
            if (floor_q == TOP_FLOOR && sub_q == '0) begin
              fault_d = 1'b1;
            end else if (sub_q == SUB_LAST) begin
              sub_d    = '0;
              floor_d  = floor_q + FLOOR_W'(1);
              moving_d = 1'b1;
              arrive_d = 1'b1;
            end else begin
              sub_d    = sub_q + SUB_ONE;
              moving_d = 1'b1;
            end
          end
          CMD_DOWN: begin
            if (floor_q == '0 && sub_q == '0) begin
              fault_d = 1'b1;
            end else if (sub_q == '0) begin
              floor_d  = floor_q - FLOOR_W'(1);
              sub_d    = SUB_LAST;
              moving_d = 1'b1;
            end else begin
              sub_d    = sub_q - SUB_ONE;
              moving_d = 1'b1;
              arrive_d = (sub_q == SUB_ONE);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Switches are registered from the next position so they track it exactly.
  always_comb begin
    sw_d = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      sw_d[i] = (floor_d == FLOOR_W'(i)) && (sub_d == '0);
    end
  end

  assign bus.switch1   = sw_q[0];
  assign bus.switch2   = sw_q[1];
  assign bus.switch3   = sw_q[2];
  assign bus.car_floor = floor_q;
  assign bus.moving    = moving_q;
  assign bus.arrive    = arrive_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_elevator_car_sim.sv
// Bench for elevator_car_sim: directed scenarios plus random commands, checked
// against a linear-position model of the car.
module tb_elevator_car_sim;
  import elevator_pkg::*;

  localparam int unsigned P = 2;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_car_sim_if bus ();

  elevator_car_sim #(.TICKS_PER_FLOOR(T), .PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  string phase = "init";

  // Reference model: pos counts sub-steps from floor 1 (0 .. 2*T).
  int pos;
  int edges;
  bit m_fault, m_moving, m_arrive;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, got, exp);
  endtask

  task automatic check_all();
    chk("switch1",   32'(bus.switch1),   32'(pos == 0));
    chk("switch2",   32'(bus.switch2),   32'(pos == int'(T)));
    chk("switch3",   32'(bus.switch3),   32'(pos == int'(2 * T)));
    chk("car_floor", 32'(bus.car_floor), 32'(pos / int'(T)));
    chk("moving",    32'(bus.moving),    32'(m_moving));
    chk("arrive",    32'(bus.arrive),    32'(m_arrive));
    chk("fault",     32'(bus.fault),     32'(m_fault));
  endtask

  task automatic cyc(input logic [1:0] cmd, input bit rst);
    bit strobe;
    bus.move_cmd = cmd;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      pos = 0; edges = 0;
      m_fault = 0; m_moving = 0; m_arrive = 0;
    end else begin
      edges++;
      strobe   = (edges % int'(P)) == 0;
      m_arrive = 0;
      if (strobe) begin
        m_moving = 0;
        if (!m_fault) begin
          if (cmd == CMD_UP) begin
            if (pos == int'(2 * T)) m_fault = 1;
            else begin pos++; m_moving = 1; m_arrive = (pos % int'(T)) == 0; end
          end else if (cmd == CMD_DOWN) begin
            if (pos == 0) m_fault = 1;
            else begin pos--; m_moving = 1; m_arrive = (pos % int'(T)) == 0; end
          end
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic run(input logic [1:0] cmd, input int n);
    for (int k = 0; k < n; k++) cyc(cmd, 1'b0);
  endtask

  initial begin
    bus.move_cmd = CMD_STOP;
    reset = 1'b1;

    phase = "reset_idle";
    cyc(CMD_STOP, 1'b1);
    cyc(CMD_STOP, 1'b1);
    chk("rst_switch1", 32'(bus.switch1), 32'd1);
    chk("rst_fault",   32'(bus.fault),   32'd0);
    run(CMD_STOP, 20);
    chk("idle_switch1", 32'(bus.switch1), 32'd1);

    phase = "const_up";
    cyc(CMD_STOP, 1'b1);
    cyc(CMD_UP, 1'b0);
    chk("edge1_switch1", 32'(bus.switch1), 32'd1);
    cyc(CMD_UP, 1'b0);
    chk("edge2_switch1", 32'(bus.switch1), 32'd0);
    run(CMD_UP, 5);
    chk("edge7_switch2", 32'(bus.switch2), 32'd0);
    cyc(CMD_UP, 1'b0);
    chk("edge8_switch2", 32'(bus.switch2), 32'd1);
    chk("edge8_arrive",  32'(bus.arrive),  32'd1);
    cyc(CMD_UP, 1'b0);
    chk("edge9_arrive",  32'(bus.arrive),  32'd0);
    run(CMD_UP, 7);
    chk("edge16_switch3",   32'(bus.switch3),   32'd1);
    chk("edge16_car_floor", 32'(bus.car_floor), 32'd2);

    phase = "overtravel_top";
    run(CMD_UP, 2);
    chk("top_fault",   32'(bus.fault),   32'd1);
    chk("top_switch3", 32'(bus.switch3), 32'd1);
    run(CMD_DOWN, 6);
    chk("frozen_switch3", 32'(bus.switch3), 32'd1);
    chk("frozen_fault",   32'(bus.fault),   32'd1);
    cyc(CMD_STOP, 1'b1);
    chk("cleared_fault", 32'(bus.fault), 32'd0);

    phase = "midshaft_stop";
    run(CMD_UP, 4);
    run(CMD_STOP, 10);
    chk("stopped_switch1", 32'(bus.switch1), 32'd0);
    run(CMD_DOWN, 3);
    chk("down_switch1_early", 32'(bus.switch1), 32'd0);
    run(CMD_DOWN, 1);
    chk("down_switch1", 32'(bus.switch1), 32'd1);
    chk("down_arrive",  32'(bus.arrive),  32'd1);
    cyc(CMD_STOP, 1'b0);
    chk("down_arrive_pulse", 32'(bus.arrive), 32'd0);

    phase = "overtravel_bottom";
    cyc(CMD_STOP, 1'b1);
    cyc(CMD_DOWN, 1'b0);
    chk("edge1_fault", 32'(bus.fault), 32'd0);
    cyc(CMD_DOWN, 1'b0);
    chk("edge2_fault", 32'(bus.fault), 32'd1);

    phase = "reset_midshaft";
    cyc(CMD_STOP, 1'b1);
    run(CMD_UP, 14);
    chk("mid_car_floor", 32'(bus.car_floor), 32'd1);
    cyc(CMD_UP, 1'b1);
    chk("mid_rst_switch1",   32'(bus.switch1),   32'd1);
    chk("mid_rst_car_floor", 32'(bus.car_floor), 32'd0);
    run(CMD_UP, 2);
    chk("restart_switch1", 32'(bus.switch1), 32'd0);

    phase = "random";
    cyc(CMD_STOP, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r < 5) ? CMD_UP : (r < 8) ? CMD_DOWN : (r < 9) ? CMD_STOP : CMD_BAD;
      if ($urandom_range(0, 24) == 0) cyc(c, 1'b1);
      else run(c, int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elevator_car_sim.md
# elevator_car_sim

Synthesizable model of the elevator car and shaft, the responder on the far side of the controller's motor-command interface. It consumes the controller's up/down/stop command and produces the three floor-alignment switches (`switch1`..`switch3`) that the `Interface` block reads, plus position and fault status. This closes the control loop on the board and in simulation without hand-driven switch stimulus.

## Interface
Parameters:
- `TICKS_PER_FLOOR`, 8: motion steps between adjacent floors; minimum 2.
- `PRESCALE`, 4: clock cycles per motion step; minimum 1 (1 = step every cycle).

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: synchronous, active-high reset.
- `move_cmd` input 2: 00 stop, 01 up, 10 down, 11 invalid (treated as stop).
- `switch1` output 1: car aligned at floor 1.
- `switch2` output 1: car aligned at floor 2.
- `switch3` output 1: car aligned at floor 3.
- `car_floor` output 2: last floor index passed or aligned, 0..2.
- `moving` output 1: a motion step occurred on the last step strobe.
- `arrive` output 1: one-cycle pulse when the car becomes aligned at a floor.
- `fault` output 1: overtravel latched; sticky until `reset`.

## Operation
- State: `floor` (0..2), `sub` (0..TICKS_PER_FLOOR-1), prescale counter, fault flag, last-step registers.
- Reset values: `floor`=0, `sub`=0, prescaler=0, `switch1`=1, `switch2`=0, `switch3`=0, `car_floor`=0, `moving`=0, `arrive`=0, `fault`=0.
- Prescaler is free-running 0..PRESCALE-1. Step strobe fires on the cycle where the count equals PRESCALE-1. `move_cmd` is sampled only on strobe cycles.
- Up step: if `sub`=TICKS_PER_FLOOR-1, then `sub`←0 and `floor`←floor+1; otherwise `sub`←sub+1.
- Down step: if `sub`=0, then `floor`←floor-1 and `sub`←TICKS_PER_FLOOR-1; otherwise `sub`←sub-1.
- Overtravel: an up command at `floor`=2, `sub`=0, or a down command at `floor`=0, `sub`=0:
  - no motion;
  - `fault`←1, and the car is frozen (all later commands are ignored) until `reset`;
  - switches hold their current aligned value.
- Stop or 11 on a strobe: position holds and `moving`←0, including mid-shaft (all switches stay 0).
- A direct reversal (up→down) between strobes is legal; the car simply steps the other way.
- `switchN` = (`floor`=N-1 && `sub`=0); at most one switch is high at any time.
- `arrive` pulses for the cycle in which `sub` becomes 0 through a motion step. A stop while already aligned does not pulse `arrive`.
- `reset` mid-motion returns the car to floor 0 aligned immediately, regardless of the previous position.

## Timing
- All outputs are registered and change on the strobe edge itself. There is no further latency.
- After `reset` deasserts, the first strobe is the PRESCALE-th rising edge.
- With PRESCALE=4, TICKS_PER_FLOOR=8, and constant up from reset:
  - `switch1` falls at edge 4;
  - `switch2` rises, with `arrive`=1 for that one cycle, at edge 32;
  - `switch3` rises at edge 64.
- A command change between strobes has no effect until the next strobe.
- `fault` asserts at the offending strobe edge and persists until `reset` is sampled high.

## Structure
- Package `elevator_pkg` holds:
  - `move_cmd` encodings `CMD_STOP`, `CMD_UP`, `CMD_DOWN`;
  - `NUM_FLOORS`=3;
  - the floor index width.
- Shared with `Interface` so the command encoding has a single source.
- Sub-module `tick_gen`: the parameterized prescaler producing the one-cycle `step` strobe, synchronous reset. It is reused later for door timing.
- The main block is a position datapath plus the fault latch. No separate FSM module is needed; the motion mode is derived from `move_cmd` on each strobe.

## Test plan
All scenarios use PRESCALE=2, TICKS_PER_FLOOR=4.
- Reset, then hold stop for 20 cycles → `switch1`=1, `car_floor`=0, `arrive`, `moving`, and `fault` all 0 throughout.
- Constant up from reset:
  - `switch1` falls at edge 2;
  - `switch2` and `arrive` rise at edge 8;
  - `switch3` rises at edge 16, with `car_floor`=2.
- Up until `sub`=2, then stop for 10 cycles, then down → all switches 0 while stopped; `switch1` returns 2 strobes later with `arrive` pulsing for one cycle.
- At floor 3 (aligned), command up → `fault`=1 at the next strobe and `switch3` stays 1. A following down command does not move the car, and `fault` clears only on `reset`.
- Down at floor 0 immediately after reset → `fault`=1 at edge 2.
- Reset asserted mid-shaft (`floor`=1, `sub`=3) → on the next edge `switch1`=1, `car_floor`=0, `fault`=0, prescaler restarts at 0.
